// File: rtl/state_estimator_mac.sv
// Sequential state estimator built around one signed MAC: predict (A*x + B*u),
// innovation (y - C*x_pred) and correction (x_pred + K*innov), one product per enabled cycle.
module state_estimator_mac #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int NOS   = 4,
  parameter int NOO   = 2,
  parameter int NOI   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    load_x0,
  input  logic signed [WIDTH-1:0] A [NOS][NOS],
  input  logic signed [WIDTH-1:0] B [NOS][NOI],
  input  logic signed [WIDTH-1:0] C [NOO][NOS],
  input  logic signed [WIDTH-1:0] K [NOS][NOO],
  input  logic signed [WIDTH-1:0] U [NOI],
  input  logic signed [WIDTH-1:0] Y [NOO],
  input  logic signed [WIDTH-1:0] X_0 [NOS],
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_pred [NOS],
  output logic signed [WIDTH-1:0] x_upd [NOS],
  output logic signed [WIDTH-1:0] innov [NOO],
  output logic                    sat_flag
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int MAXD  = (NOS + NOI > NOO) ? NOS + NOI : NOO;
  localparam int CW    = $clog2(MAXD + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PRED, INNOV, CORR, DONE} state_t;

  state_t                   state;
  state_t                   nxt_state;
  logic [1:0]               mode_q;
  logic [CW-1:0]            row;
  logic [CW-1:0]            col;
  logic signed [ACC_W-1:0]  acc;
  logic signed [WIDTH-1:0]  u_cap [NOI];
  logic signed [WIDTH-1:0]  y_cap [NOO];

  logic signed [WIDTH-1:0]  mul_a;
  logic signed [WIDTH-1:0]  mul_b;
  logic signed [WIDTH-1:0]  add_term;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  add_ext;
  logic signed [ACC_W-1:0]  full;
  logic signed [WIDTH-1:0]  res_word;
  logic                     res_ovf;
  logic                     last_col;
  logic                     last_row;

  function automatic logic signed [ACC_W-1:0] shift_frac(input logic signed [ACC_W-1:0] v);
    return v >>> FRAC;
  endfunction

  function automatic logic sat_ovf(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_word(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[WIDTH-1:0];
    else
      return v[WIDTH-1:0];
  endfunction

  // Operand steering: (row, col) walks the active matrix row-major
  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    add_term  = '0;
    last_col  = 1'b0;
    last_row  = 1'b0;
    nxt_state = state;
    case (state)
      PRED: begin
        for (int i = 0; i < NOS; i++) begin
          for (int j = 0; j < NOS; j++) begin
            if (row == CW'(i) && col == CW'(j)) begin
              mul_a = A[i][j];
              mul_b = x_upd[j];
            end
          end
          for (int k = 0; k < NOI; k++) begin
            if (row == CW'(i) && col == CW'(NOS + k)) begin
              mul_a = B[i][k];
              mul_b = u_cap[k];
            end
          end
        end
        last_col  = (col == CW'(NOS + NOI - 1));
        last_row  = (row == CW'(NOS - 1));
        nxt_state = (mode_q == 2'b10) ? INNOV : DONE;
      end
      INNOV: begin
        for (int r = 0; r < NOO; r++) begin
          if (row == CW'(r)) begin
            add_term = y_cap[r];
            for (int j = 0; j < NOS; j++) begin
              if (col == CW'(j)) begin
                mul_a = C[r][j];
                mul_b = x_pred[j];
              end
            end
          end
        end
        last_col  = (col == CW'(NOS - 1));
        last_row  = (row == CW'(NOO - 1));
        nxt_state = CORR;
      end
      CORR: begin
        for (int i = 0; i < NOS; i++) begin
          if (row == CW'(i)) begin
            add_term = x_pred[i];
            for (int r = 0; r < NOO; r++) begin
              if (col == CW'(r)) begin
                mul_a = K[i][r];
                mul_b = innov[r];
              end
            end
          end
        end
        last_col  = (col == CW'(NOO - 1));
        last_row  = (row == CW'(NOS - 1));
        nxt_state = DONE;
      end
      default: ;
    endcase

    prod    = PW'(mul_a) * PW'(mul_b);
    sum     = acc + ACC_W'(prod);
    add_ext = ACC_W'(add_term) <<< FRAC;
    // The additive term joins at full precision; innovation subtracts the dot product
    full    = (state == INNOV) ? (add_ext - sum) : (add_ext + sum);
  end

  assign res_word = sat_word(shift_frac(full));
  assign res_ovf  = sat_ovf(shift_frac(full));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      mode_q   <= '0;
      row      <= '0;
      col      <= '0;
      acc      <= '0;
      for (int i = 0; i < NOS; i++) begin
        x_pred[i] <= '0;
        x_upd[i]  <= '0;
      end
      for (int r = 0; r < NOO; r++) begin
        innov[r] <= '0;
        y_cap[r] <= '0;
      end
      for (int k = 0; k < NOI; k++) u_cap[k] <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (start && mode != 2'b11) begin
            for (int k = 0; k < NOI; k++) u_cap[k] <= U[k];
            for (int r = 0; r < NOO; r++) y_cap[r] <= Y[r];
            mode_q   <= mode;
            sat_flag <= 1'b0;
            busy     <= 1'b1;
            row      <= '0;
            col      <= '0;
            acc      <= '0;
            state    <= (mode == 2'b01) ? INNOV : PRED;
          end else if (load_x0) begin
            for (int i = 0; i < NOS; i++) begin
              x_pred[i] <= X_0[i];
              x_upd[i]  <= X_0[i];
            end
          end
        end
        PRED, INNOV, CORR: begin
          if (last_col) begin
            acc <= '0;
            col <= '0;
            if (res_ovf) sat_flag <= 1'b1;
            for (int i = 0; i < NOS; i++) begin
              if (row == CW'(i) && state == PRED) x_pred[i] <= res_word;
              if (row == CW'(i) && state == CORR) x_upd[i]  <= res_word;
            end
            for (int r = 0; r < NOO; r++) begin
              if (row == CW'(r) && state == INNOV) innov[r] <= res_word;
            end
            if (last_row) begin
              row   <= '0;
              state <= nxt_state;
              done  <= (nxt_state == DONE);
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= sum;
            col <= col + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_estimator_mac.sv
// Bench for state_estimator_mac: directed tables, corner sequences and random
// operations compared against a plain-arithmetic estimator model.
`timescale 1ns/1ps
module tb_state_estimator_mac;
  localparam int W = 16, NOS = 4, NOO = 2, NOI = 2;

  logic clk = 1'b0;
  logic reset, clk_en, start, load_x0;
  logic [1:0] mode;
  logic signed [W-1:0] A [NOS][NOS];
  logic signed [W-1:0] B [NOS][NOI];
  logic signed [W-1:0] C [NOO][NOS];
  logic signed [W-1:0] K [NOS][NOO];
  logic signed [W-1:0] U [NOI];
  logic signed [W-1:0] Y [NOO];
  logic signed [W-1:0] X_0 [NOS];
  logic busy, done, sat_flag;
  logic signed [W-1:0] x_pred [NOS];
  logic signed [W-1:0] x_upd [NOS];
  logic signed [W-1:0] innov [NOO];

  state_estimator_mac #(.WIDTH(16), .FRAC(8), .NOS(4), .NOO(2), .NOI(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .mode(mode), .load_x0(load_x0),
    .A(A), .B(B), .C(C), .K(K), .U(U), .Y(Y), .X_0(X_0),
    .busy(busy), .done(done), .x_pred(x_pred), .x_upd(x_upd), .innov(innov), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  longint mxp [NOS];
  longint mxu [NOS];
  longint mi [NOO];
  bit msat;

  typedef struct {
    logic signed [15:0] a, x, b, u, exp_xp;
    logic exp_sat;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scale(input longint full, output longint res);
    longint v;
    v = full >>> 8;
    if (v > 32767) begin res = 32767; msat = 1; end
    else if (v < -32768) begin res = -32768; msat = 1; end
    else res = v;
  endtask

  task automatic model_op(input int md);
    longint s, res;
    msat = 0;
    if (md != 1) begin
      for (int i = 0; i < NOS; i++) begin
        s = 0;
        for (int j = 0; j < NOS; j++) s += longint'(A[i][j]) * mxu[j];
        for (int k = 0; k < NOI; k++) s += longint'(B[i][k]) * longint'(U[k]);
        scale(s, res);
        mxp[i] = res;
      end
    end
    if (md != 0) begin
      for (int r = 0; r < NOO; r++) begin
        s = longint'(Y[r]) * 256;
        for (int j = 0; j < NOS; j++) s -= longint'(C[r][j]) * mxp[j];
        scale(s, res);
        mi[r] = res;
      end
      for (int i = 0; i < NOS; i++) begin
        s = mxp[i] * 256;
        for (int r = 0; r < NOO; r++) s += longint'(K[i][r]) * mi[r];
        scale(s, res);
        mxu[i] = res;
      end
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < NOS; i++) begin mxp[i] = 0; mxu[i] = 0; end
    for (int r = 0; r < NOO; r++) mi[r] = 0;
    msat = 0;
  endtask

  task automatic chk_outputs(input string tag);
    for (int i = 0; i < NOS; i++) begin
      chk($sformatf("%s x_pred[%0d]", tag, i), x_pred[i], mxp[i]);
      chk($sformatf("%s x_upd[%0d]", tag, i), x_upd[i], mxu[i]);
    end
    for (int r = 0; r < NOO; r++) chk($sformatf("%s innov[%0d]", tag, r), innov[r], mi[r]);
    chk($sformatf("%s sat_flag", tag), sat_flag, msat);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " sat_flag"}, sat_flag, 0);
    for (int i = 0; i < NOS; i++) begin
      chk($sformatf("%s x_pred[%0d]", tag, i), x_pred[i], 0);
      chk($sformatf("%s x_upd[%0d]", tag, i), x_upd[i], 0);
    end
    for (int r = 0; r < NOO; r++) chk($sformatf("%s innov[%0d]", tag, r), innov[r], 0);
  endtask

  function automatic logic signed [15:0] rnd16();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 1024)) - 16'sd512;
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NOS; i++) begin
      for (int j = 0; j < NOS; j++) A[i][j] = rnd16();
      for (int k = 0; k < NOI; k++) B[i][k] = rnd16();
      for (int r = 0; r < NOO; r++) K[i][r] = rnd16();
      X_0[i] = rnd16();
    end
    for (int r = 0; r < NOO; r++) begin
      for (int j = 0; j < NOS; j++) C[r][j] = rnd16();
      Y[r] = rnd16();
    end
    for (int k = 0; k < NOI; k++) U[k] = rnd16();
  endtask

  task automatic do_load();
    load_x0 = 1'b1;
    tick();
    load_x0 = 1'b0;
    for (int i = 0; i < NOS; i++) begin mxp[i] = X_0[i]; mxu[i] = X_0[i]; end
  endtask

  task automatic do_op(input int md, input int stall_at, input int stall_len,
                       input bit poke, input bit with_load, output int lat);
    int exp_t;
    bit stalled;
    exp_t = (md == 0) ? 24 : (md == 1) ? 16 : 40;
    model_op(md);
    start = 1'b1;
    mode = 2'(md);
    load_x0 = with_load;
    tick();
    start = poke;
    if (poke) mode = 2'b01;
    load_x0 = 1'b0;
    for (int k = 0; k < NOI; k++) U[k] = rnd16();
    for (int r = 0; r < NOO; r++) Y[r] = rnd16();
    chk("busy_on_accept", busy, 1);
    chk("sat_clear_on_accept", sat_flag, 0);
    lat = 0;
    stalled = 0;
    while (done !== 1'b1 && lat < 300) begin
      if (!stalled && stall_len > 0 && lat == stall_at) begin
        clk_en = 1'b0;
        repeat (stall_len) begin tick(); lat++; end
        clk_en = 1'b1;
        stalled = 1;
      end else begin
        tick();
        lat++;
      end
    end
    start = 1'b0;
    chk($sformatf("latency mode%0d", md), lat, exp_t + stall_len);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_release", busy, 0);
    chk_outputs($sformatf("op mode%0d", md));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic signed [W-1:0] sv_xp [NOS];
    logic signed [W-1:0] sv_xu [NOS];
    logic signed [W-1:0] sv_in [NOO];
    logic signed [W-1:0] su [NOI];
    logic signed [W-1:0] sy [NOO];

    tbl[0] = '{16'sh0100, 16'sh0050, 16'sh0000, 16'sh0000, 16'sh0050, 1'b0};
    tbl[1] = '{16'sh0080, 16'sh0101, 16'sh0000, 16'sh0000, 16'sh0080, 1'b0};
    tbl[2] = '{16'shFF00, 16'sh0003, 16'sh0000, 16'sh0000, 16'shFFFD, 1'b0};
    tbl[3] = '{16'sh0080, 16'shFFFF, 16'sh0000, 16'sh0000, 16'shFFFF, 1'b0};
    tbl[4] = '{16'sh0100, 16'sh0010, 16'sh0100, 16'sh0020, 16'sh0050, 1'b0};
    tbl[5] = '{16'sh7FFF, 16'sh8000, 16'sh0000, 16'sh0000, 16'sh8000, 1'b1};
    tbl[6] = '{16'sh0000, 16'sh0000, 16'sh4000, 16'sh4000, 16'sh7FFF, 1'b1};

    reset = 1'b0; clk_en = 1'b1; start = 1'b0; mode = 2'b00; load_x0 = 1'b0;
    for (int i = 0; i < NOS; i++) begin
      for (int j = 0; j < NOS; j++) A[i][j] = '0;
      for (int k = 0; k < NOI; k++) B[i][k] = '0;
      for (int r = 0; r < NOO; r++) K[i][r] = '0;
      X_0[i] = '0;
    end
    for (int r = 0; r < NOO; r++) begin
      for (int j = 0; j < NOS; j++) C[r][j] = '0;
      Y[r] = '0;
    end
    for (int k = 0; k < NOI; k++) U[k] = '0;
    model_zero();

    tick();
    check_zero("reset_state");
    tick();
    reset = 1'b1;
    tick();

    // load_x0 with clk_en low must not take effect
    for (int i = 0; i < NOS; i++) X_0[i] = 16'(i + 1);
    clk_en = 1'b0; load_x0 = 1'b1;
    tick();
    chk_outputs("clk_en_hold");
    load_x0 = 1'b0; clk_en = 1'b1;

    // Identity predict reproduces X_0
    for (int i = 0; i < NOS; i++) begin
      A[i][i] = 16'sh0100;
      X_0[i] = 16'((i + 1) * 256);
    end
    do_load();
    do_op(0, 0, 0, 0, 0, lat);
    for (int i = 0; i < NOS; i++) chk($sformatf("ident x_pred[%0d]", i), x_pred[i], (i + 1) * 256);
    chk("ident sat_flag", sat_flag, 0);

    // Update-only run with known gains
    C[0][0] = 16'sh0100; C[1][1] = 16'sh0100;
    Y[0] = 16'sh0300; Y[1] = 16'sh0200;
    K[0][0] = 16'sh0080; K[1][1] = 16'sh0080;
    do_op(1, 0, 0, 0, 0, lat);
    chk("upd innov[0]", innov[0], 16'sh0200);
    chk("upd innov[1]", innov[1], 0);
    chk("upd x_upd[0]", x_upd[0], 16'sh0200);
    chk("upd x_upd[1]", x_upd[1], 16'sh0200);
    chk("upd x_upd[2]", x_upd[2], 16'sh0300);
    chk("upd x_upd[3]", x_upd[3], 16'sh0400);

    // Positive saturation, then a fresh start clears the flag
    for (int i = 0; i < NOS; i++) begin
      A[i][i] = 16'sh7F00;
      X_0[i] = 16'sh0400;
    end
    do_load();
    do_op(0, 0, 0, 0, 0, lat);
    for (int i = 0; i < NOS; i++) chk($sformatf("satp x_pred[%0d]", i), x_pred[i], 16'sh7FFF);
    chk("satp sat_flag", sat_flag, 1);
    do_op(0, 0, 0, 0, 0, lat);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < NOS; i++) begin
        for (int j = 0; j < NOS; j++) A[i][j] = (i == j) ? tbl[t].a : 16'sh0000;
        for (int k = 0; k < NOI; k++) B[i][k] = tbl[t].b;
        X_0[i] = tbl[t].x;
      end
      for (int k = 0; k < NOI; k++) U[k] = tbl[t].u;
      do_load();
      do_op(0, 0, 0, 0, 0, lat);
      for (int i = 0; i < NOS; i++)
        chk($sformatf("tbl%0d x_pred[%0d]", t, i), x_pred[i], tbl[t].exp_xp);
      chk($sformatf("tbl%0d sat_flag", t), sat_flag, tbl[t].exp_sat);
    end

    // Reserved mode in IDLE is ignored
    start = 1'b1; mode = 2'b11;
    repeat (3) begin
      tick();
      chk("mode11 busy", busy, 0);
      chk("mode11 done", done, 0);
    end
    start = 1'b0;
    chk_outputs("mode11");

    // start held high during busy is ignored
    rand_inputs();
    do_load();
    do_op(0, 0, 0, 1, 0, lat);
    do_op(2, 0, 0, 1, 0, lat);

    // Stall mid-PRED gives identical results, latency stretched
    rand_inputs();
    do_load();
    for (int k = 0; k < NOI; k++) su[k] = U[k];
    for (int r = 0; r < NOO; r++) sy[r] = Y[r];
    do_op(2, 0, 0, 0, 0, lat);
    for (int i = 0; i < NOS; i++) begin sv_xp[i] = x_pred[i]; sv_xu[i] = x_upd[i]; end
    for (int r = 0; r < NOO; r++) sv_in[r] = innov[r];
    for (int k = 0; k < NOI; k++) U[k] = su[k];
    for (int r = 0; r < NOO; r++) Y[r] = sy[r];
    do_load();
    do_op(2, 8, 10, 0, 0, lat);
    for (int i = 0; i < NOS; i++) begin
      chk($sformatf("stall x_pred[%0d]", i), x_pred[i], sv_xp[i]);
      chk($sformatf("stall x_upd[%0d]", i), x_upd[i], sv_xu[i]);
    end
    for (int r = 0; r < NOO; r++) chk($sformatf("stall innov[%0d]", r), innov[r], sv_in[r]);

    for (int n = 0; n < 20; n++) begin
      int md;
      bit wl;
      rand_inputs();
      if ($urandom_range(0, 1) == 1) do_load();
      md = $urandom_range(0, 2);
      wl = ($urandom_range(0, 4) == 0);
      if (wl) for (int i = 0; i < NOS; i++) X_0[i] = rnd16();
      do_op(md, 0, 0, 0, wl, lat);
    end

    // Asynchronous reset in the middle of INNOV
    rand_inputs();
    do_load();
    start = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("busy_mid_innov", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("reset_mid_innov");
    model_zero();
    repeat (2) begin
      tick();
      chk("reset_hold done", done, 0);
    end
    reset = 1'b1;
    tick();
    do_op(0, 0, 0, 0, 0, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
